// File: rtl/data_memory_responder_if.sv
// Load/store bus between the single-cycle core (master) and the wait-stated
// data memory (slave).
interface data_memory_responder_if;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] data_rd;
  logic        dm_ready;
  logic        dm_err;
  logic        stall;

  modport master (
    output address, data_wr, dm_rd, dm_wr,
    input  data_rd, dm_ready, dm_err, stall
  );

  modport slave (
    input  address, data_wr, dm_rd, dm_wr,
    output data_rd, dm_ready, dm_err, stall
  );
endinterface

// File: rtl/data_memory_responder.sv
// Wait-stated data memory: latches a load/store, stalls the core for
// WAIT_STATES cycles, then completes with a one-cycle dm_ready pulse.
module data_memory_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_memory_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic [31:0] data_rd_q, data_rd_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic              req;
  logic              do_acc;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic              mem_we;
  logic              stall;

  assign req = bus.dm_rd | bus.dm_wr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic, including request capture and wait counting
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d     = bus.address;
          wdata_d    = bus.data_wr;
          rd_d       = bus.dm_rd;
          wr_d       = bus.dm_wr;
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge itself,
  // so it must see the live bus rather than the not-yet-loaded latches.
  always_comb begin
    do_acc    = (state_d == S_RESP) && (state_q != S_RESP);
    acc_addr  = (state_q == S_IDLE) ? bus.address : addr_q;
    acc_wdata = (state_q == S_IDLE) ? bus.data_wr : wdata_q;
    acc_rd    = (state_q == S_IDLE) ? bus.dm_rd   : rd_q;
    acc_wr    = (state_q == S_IDLE) ? bus.dm_wr   : wr_q;
    acc_err   = (acc_addr[1:0] != 2'b00)
              | (acc_addr[31:ADDR_W+2] != '0)
              | (acc_rd & acc_wr);
    acc_idx   = acc_addr[ADDR_W+1:2];
    mem_we    = do_acc & acc_wr & ~acc_err;
    data_rd_d = data_rd_q;
    if (do_acc && acc_rd && !acc_err) data_rd_d = mem_q[acc_idx];
    ready_d   = do_acc;
    err_d     = do_acc & acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      data_rd_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[ADDR_W'(i)] <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      data_rd_q <= data_rd_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      if (mem_we) mem_q[acc_idx] <= acc_wdata;
    end
  end

  // Output logic
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = req;
      S_WAIT:  stall = 1'b1;
      S_RESP:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  assign bus.stall    = stall;
  assign bus.data_rd  = data_rd_q;
  assign bus.dm_ready = ready_q;
  assign bus.dm_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table, hand
// sequences for multi-cycle corners, and randomized accesses against a model.
module tb_data_memory_responder;

  localparam int unsigned WS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_responder_if ifa ();
  data_memory_responder_if ifz ();

  data_memory_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  data_memory_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifz.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word array plus the last successfully read value.
  logic [31:0] mem_m [64];
  logic [31:0] last_rd;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    last_rd = '0;
  endtask

  task automatic model_acc(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic err, output logic [31:0] rdv);
    logic [5:0] idx;
    err = (a % 4 != 0) || (a >= 32'd256) || (rd && wr);
    idx = 6'(a / 4);
    if (!err && wr) mem_m[idx] = d;
    if (!err && rd) last_rd = mem_m[idx];
    rdv = last_rd;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    ifa.dm_rd   = rd;
    ifa.dm_wr   = wr;
    ifa.address = a;
    ifa.data_wr = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
    end
  endtask

  // One access on the WS=2 instance, request held until dm_ready.
  task automatic run_acc(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rd);
    bit done;
    @(negedge clk);
    drive(rd, wr, a, d);
    #1;
    chk({name, " stall c0"}, ifa.stall, 1'b1);
    chk({name, " ready c0"}, ifa.dm_ready, 1'b0);
    done = 0;
    for (int cyc = 1; cyc <= int'(WS) + 4 && !done; cyc++) begin
      @(negedge clk);
      #1;
      if (ifa.dm_ready) begin
        done = 1;
        chk({name, " ready cycle"}, cyc, WS + 1);
        chk({name, " err"}, ifa.dm_err, exp_err);
        chk({name, " data_rd"}, ifa.data_rd, exp_rd);
        chk({name, " stall resp"}, ifa.stall, 1'b0);
      end else begin
        chk({name, " stall wait"}, ifa.stall, 1'b1);
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no dm_ready within budget", name);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic        merr;
    logic [31:0] mrd;
    bit          done;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_003C, 32'h0,          1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,          1'b1, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D,  1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h5555_5555,  1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'h1234_5678,  1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'h1234_5678};
    tbl[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,          1'b1, 32'h1234_5678};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0003, 32'h7777_7777,  1'b1, 32'h1234_5678};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0};

    drive(1'b0, 1'b0, '0, '0);
    ifz.dm_rd = 1'b0; ifz.dm_wr = 1'b0; ifz.address = '0; ifz.data_wr = '0;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst data_rd", ifa.data_rd, 32'h0);
    chk("rst ready", ifa.dm_ready, 1'b0);
    chk("rst err", ifa.dm_err, 1'b0);
    chk("rst stall", ifa.stall, 1'b0);
    chk("rst0 data_rd", ifz.data_rd, 32'h0);
    chk("rst0 ready", ifz.dm_ready, 1'b0);
    chk("rst0 stall", ifz.stall, 1'b0);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      model_acc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, merr, mrd);
      run_acc($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
              tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rd);
      idle(1);
    end

    // Inputs changed mid-access must be ignored
    model_acc(1'b0, 1'b1, 32'h04, 32'h1111_1111, merr, mrd);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h04, 32'h1111_1111);
    #1 chk("chg stall c0", ifa.stall, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h08, 32'h2222_2222);
    done = 0;
    for (int cyc = 1; cyc <= 6 && !done; cyc++) begin
      #1;
      if (ifa.dm_ready) begin
        done = 1;
        chk("chg ready cycle", cyc, WS + 1);
        chk("chg err", ifa.dm_err, 1'b0);
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL chg: no dm_ready within budget");
    end
    idle(1);
    run_acc("chg rd04", 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h1111_1111);
    model_acc(1'b1, 1'b0, 32'h04, 32'h0, merr, mrd);
    model_acc(1'b1, 1'b0, 32'h08, 32'h0, merr, mrd);
    run_acc("chg rd08", 1'b1, 1'b0, 32'h08, 32'h0, merr, mrd);
    idle(1);

    // Reset aborts a pending write
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rstmid ready", ifa.dm_ready, 1'b0);
      chk("rstmid stall", ifa.stall, 1'b0);
      @(negedge clk);
    end
    chk("rstmid data_rd", ifa.data_rd, 32'h0);
    run_acc("rstmid rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    idle(1);

    // Back-to-back on the zero-wait instance
    @(negedge clk);
    ifz.dm_wr = 1'b1; ifz.address = 32'h00; ifz.data_wr = 32'h0000_00A0;
    #1;
    chk("b2b wr0 stall", ifz.stall, 1'b1);
    chk("b2b wr0 ready0", ifz.dm_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("b2b wr0 ready", ifz.dm_ready, 1'b1);
    chk("b2b wr0 err", ifz.dm_err, 1'b0);
    @(negedge clk);
    ifz.address = 32'h04; ifz.data_wr = 32'h0000_00B4;
    #1 chk("b2b wr4 stall", ifz.stall, 1'b1);
    @(negedge clk);
    #1 chk("b2b wr4 ready", ifz.dm_ready, 1'b1);
    @(negedge clk);
    ifz.dm_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifz.dm_rd   = 1'b1;
      ifz.address = (k < 4) ? 32'h00 : 32'h04;
      #1;
      chk($sformatf("b2b ready k%0d", k), ifz.dm_ready, 1'((k % 2) == 1));
      chk($sformatf("b2b stall k%0d", k), ifz.stall, 1'((k % 2) == 0));
      if (k % 2 == 1)
        chk($sformatf("b2b data k%0d", k), ifz.data_rd, (k < 4) ? 32'hA0 : 32'hB4);
    end
    @(negedge clk);
    ifz.dm_rd = 1'b0;
    #1 chk("b2b idle stall", ifz.stall, 1'b0);

    // Randomized accesses against the model
    for (int n = 0; n < 150; n++) begin
      logic        rd, wr;
      logic [31:0] a, d;
      int unsigned sel, kind;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 63)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, 255));
      else if (sel == 8) a = $urandom | 32'h0000_0100;
      else               a = 32'($urandom_range(0, 3)) * 4;
      d    = $urandom;
      kind = $urandom_range(0, 9);
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      model_acc(rd, wr, a, d, merr, mrd);
      run_acc($sformatf("rnd%0d", n), rd, wr, a, d, merr, mrd);
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
